// File: rtl/mul6_seq_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package mul6_seq_pkg;

   // Default operand width of the multiplier and its adder.
   localparam int N_DEF = 6;

   // Controller states: waiting, iterating, one-cycle completion.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Width of an iteration counter that must hold the values 0..n.
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/add6bit.sv
// N-bit ripple-carry adder, purely combinational.
module add6bit #(
   parameter int N = 6
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] s,
   output logic         cout
);

   logic [N:0] carry;

   // Ripple the carry bit by bit from cin towards cout.
   always_comb begin
      carry    = '0;
      s        = '0;
      carry[0] = cin;
      for (int i = 0; i < N; i++) begin
         s[i]       = a[i] ^ b[i] ^ carry[i];
         carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
   end

   assign cout = carry[N];

endmodule

// File: rtl/mul6_seq.sv
// Sequential unsigned multiplier: one shared ripple adder, N iterations,
// start/busy/done handshake and a registered 2N-bit product.
module mul6_seq
   import mul6_seq_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] product
);

   localparam int CNT_W = cnt_w(N);

   state_t           state_q,   state_d;
   logic [N-1:0]     m_q,       m_d;
   logic [N-1:0]     acc_q,     acc_d;
   logic [N-1:0]     q_q,       q_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic [2*N-1:0]   product_q, product_d;

   logic [N-1:0]     sum;
   logic             sum_cout;

   // The single adder always sees accumulator + multiplicand; the FSM
   // decides from Q[0] whether that sum is kept or bypassed.
   add6bit #(.N(N)) u_add (
      .a    (acc_q),
      .b    (m_q),
      .cin  (1'b0),
      .s    (sum),
      .cout (sum_cout)
   );

   // Next-state and datapath update; every register holds by default.
   always_comb begin
      state_d   = state_q;
      m_d       = m_q;
      acc_d     = acc_q;
      q_d       = q_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               m_d     = a;
               q_d     = b;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            // Right shift of {carry, A, Q}; the carry becomes the new A msb.
            if (q_q[0]) begin
               {acc_d, q_d} = {sum_cout, sum, q_q[N-1:1]};
            end else begin
               {acc_d, q_d} = {1'b0, acc_q, q_q[N-1:1]};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(N - 1)) begin
               product_d = {acc_d, q_d};
               state_d   = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         m_q       <= '0;
         acc_q     <= '0;
         q_q       <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         m_q       <= m_d;
         acc_q     <= acc_d;
         q_q       <= q_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   assign busy    = (state_q == RUN);
   assign done    = (state_q == DONE);
   assign product = product_q;

endmodule

// File: tb/tb_mul6_seq.sv
// Scoreboard bench for mul6_seq: directed operands with hand-computed
// products are queued at issue time and popped by a monitor on each done.
module tb_mul6_seq;

   localparam int N = 6;

   logic           clk;
   logic           rst_n;
   logic           start;
   logic [N-1:0]   a;
   logic [N-1:0]   b;
   logic           busy;
   logic           done;
   logic [2*N-1:0] product;

   int n_compared   = 0;
   int n_mismatched = 0;

   int exp_q[$];
   int busy_run  = 0;
   logic prev_done = 1'b0;

   mul6_seq #(.N(N)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something hangs.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic check_output(input string name, input int actual, input int expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Monitor: pop and compare on each done, check pulse width and busy length.
   always @(negedge clk) begin
      if (!rst_n) begin
         busy_run  = 0;
         prev_done = 1'b0;
      end else begin
         if (busy) busy_run++;
         if (done) begin
            if (exp_q.size() == 0) begin
               check_output("unexpected_done", int'(product), -1);
            end else begin
               check_output("product", int'(product), exp_q.pop_front());
            end
            check_output("busy_cycles", busy_run, N);
            check_output("done_pulse", int'(prev_done), 0);
            busy_run = 0;
         end
         prev_done = done;
      end
   end

   // Issue one operation, queue its expected product, wait for done.
   task automatic apply_stimulus(input int av, input int bv, input int expv, output int lat);
      start = 1'b1;
      a     = N'(av);
      b     = N'(bv);
      exp_q.push_back(expv);
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         lat++;
         if (lat == 1) start = 1'b0;
         if (done) break;
      end
      if (!done) check_output("done_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   int lat;
   int held_a[4] = '{9, 63, 17, 40};
   int held_b[4] = '{7, 1, 60, 50};
   int held_p[4] = '{63, 63, 1020, 2000};

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (2) @(posedge clk);
      #1;
      check_output("reset_busy", int'(busy), 0);
      check_output("reset_done", int'(done), 0);
      check_output("reset_product", int'(product), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic vectors, latency checked on each.
      apply_stimulus(0, 0, 0, lat);
      check_output("latency_0x0", lat, 7);
      apply_stimulus(63, 63, 3969, lat);
      check_output("latency_63x63", lat, 7);
      apply_stimulus(5, 3, 15, lat);
      apply_stimulus(32, 2, 64, lat);
      apply_stimulus(1, 63, 63, lat);

      // start pulses during RUN and DONE must be ignored.
      start = 1'b1; a = 6'd32; b = 6'd2;
      exp_q.push_back(64);
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; a = 6'd7; b = 6'd7;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (done) break;
         @(posedge clk); #1;
      end
      check_output("ignore_done_seen", int'(done), 1);
      start = 1'b1; a = 6'd7; b = 6'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      check_output("ignore_product_held", int'(product), 64);
      check_output("ignore_idle_busy", int'(busy), 0);

      // Reset at the 3rd RUN edge aborts the operation.
      start = 1'b1; a = 6'd63; b = 6'd63;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check_output("abort_busy", int'(busy), 0);
      check_output("abort_done", int'(done), 0);
      check_output("abort_product", int'(product), 0);
      repeat (10) @(posedge clk);
      #1;
      check_output("abort_no_done", int'(product), 0);
      apply_stimulus(2, 3, 6, lat);

      // start held high: one acceptance every 8 edges.
      start = 1'b1;
      for (int k = 0; k < 4; k++) begin
         a = N'(held_a[k]);
         b = N'(held_b[k]);
         exp_q.push_back(held_p[k]);
         for (int j = 1; j <= 8; j++) begin
            @(posedge clk); #1;
            if (j == 1) begin
               a = 6'd63;
               b = 6'd63;
            end
            if (j == 7) check_output("held_done_slot", int'(done), 1);
            if (j == 8) check_output("held_idle_slot", int'(done), 0);
         end
      end
      start = 1'b0;

      repeat (12) @(posedge clk);
      #1;
      check_output("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/mul6_seq.md
# mul6_seq

Sequential N-bit unsigned shift-and-add multiplier controller. It time-shares a single instance of the team's N-bit ripple adder, `add6bit`, over N iterations to produce a 2N-bit product. It sits beside the adder in the arithmetic lab datapath. It turns the purely combinational adder into a multi-cycle multiply unit with a start/busy/done handshake.

## Interface
- N, default 6: operand width; the adder instance is built at the same width.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, synchronous and active-low.
- start  input  1  request a multiply; sampled only in IDLE.
- a  input  N  multiplicand; captured on the accepted start edge.
- b  input  N  multiplier; captured on the accepted start edge.
- busy  output  1  high while iterating (RUN state).
- done  output  1  one-cycle pulse: product is valid and newly updated.
- product  output  2N  registered result; holds until the next completion.

## Operation
- Internal registers:
  - M (N bits): multiplicand.
  - A (N bits): accumulator.
  - Q (N bits): multiplier, shifting.
  - cnt: iteration counter, $clog2(N+1) bits.
  - state: IDLE, RUN, DONE.
- Reset (rst_n=0 at a clock edge):
  - state goes to IDLE.
  - M, A, Q, cnt, product are cleared to 0.
  - busy=0, done=0.
  - Reset overrides everything, including mid-RUN. The aborted operation is discarded and product stays 0.
- IDLE:
  - On start=1: M←a, Q←b, A←0, cnt←0, go to RUN.
  - On start=0: hold all registers.
- RUN, once per cycle:
  - The adder computes {c,s} = A + M with cin=0.
  - If Q[0]=1, then {A,Q} ← {c,s,Q[N-1:1]}.
  - If Q[0]=0, then {A,Q} ← {0,A,Q[N-1:1]}. This is a right shift of the (2N+1)-bit value {c,A,Q}.
  - cnt←cnt+1.
  - When cnt==N-1 at an edge (the N-th iteration), go to DONE.
- DONE: for exactly one cycle, then unconditionally to IDLE.
- product is loaded with the final {A,Q} on the edge that performs the N-th iteration. It is visible in the DONE cycle. No other state changes product.
- Arithmetic:
  - Unsigned only.
  - The carry from the adder is never lost; the maximum product (2^N-1)^2 fits in 2N bits.
  - The adder's cout feeds the shift; cin is tied 0.
- start is ignored in RUN and DONE. No queuing, no error flag.
- a and b may change freely after the accepted start edge.

## Timing
- Edge 0: start=1 sampled in IDLE.
- Edges 1..N: N iterations; busy=1 during the cycles following edges 0..N-1.
- After edge N: state=DONE, done=1, busy=0, product valid.
- After edge N+1: IDLE; done=0; product holds.
- Latency: N+1 edges from the accepted start to the done cycle. For N=6 this is 7.
- Minimum issue interval: N+2 cycles. With start held permanently high, a new operation is accepted on every edge in IDLE, which is every N+2 edges.
- All outputs are registered or decoded directly from state. There is no combinational path from inputs to outputs.

## Structure
- Package mul6_seq_pkg:
  - state enum {IDLE, RUN, DONE}.
  - Default width constant N_DEF=6.
  - Counter-width function/constant CNT_W = $clog2(N+1).
- Sub-module: exactly one instance of `add6bit`, parameterised with N. No second adder and no `*` operator.
- Control FSM and datapath registers live in mul6_seq itself; no further split.

## Test plan
- Reset, then a=0, b=0, start for 1 cycle -> done on the 7th edge after start, product=0x000; busy high for exactly 6 cycles.
- a=63, b=63 -> product=3969 (0xF81); checks carry-out into the shift on every iteration.
- a=5, b=3 -> 15; a=32, b=2 -> 64; a=1, b=63 -> 63; each with done a single-cycle pulse.
- start pulsed again with a=7, b=7 during RUN and during DONE -> ignored; the result of the first operation is unchanged, and no second done appears.
- rst_n=0 at the 3rd RUN edge of a=63, b=63 -> next cycle IDLE, busy=0, done=0, product=0; a subsequent a=2, b=3 yields 6.
- start held high for 30 cycles, with operands changing on each acceptance -> acceptances every 8 edges, each product correct for the operands captured at its own start edge.
